pipe_controller_v2: RTL and testbench
=====================================

# pipe_controller_v2

Parametrised control unit for the five-stage RV32I pipeline. It decodes `InstrD` in Decode and carries control through registered E, M and W stages. It adds the following:
- E- and M-stage stall and flush control.
- Full branch-condition resolution (beq/bne/blt/bge/bltu/bgeu) from ALU flags.
- jal, jalr and lui support.
- An illegal-instruction flag pipelined to M.

## Interface
- `ALU_W`, default 4: ALUControl width, must be ≥4; bits above [3] are driven 0.
- `ILLEGAL_EN`, default 1: when 0, `IllegalM` is tied 0 and the illegal-flag register bit is removed.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high; clears every pipeline control register.
- `InstrD` input 32: instruction in Decode.
- `ZeroE`, `NegE`, `CarryE`, `OverflowE` input 1 each: ALU flags of the E-stage subtraction. `CarryE=1` means no borrow.
- `StallE` input 1: hold the E-stage control register.
- `FlushE` input 1: load a bubble into the E-stage control register.
- `FlushM` input 1: load a bubble into the M-stage control register.
- `ImmSrcD` output 3: immediate type. 000=I, 001=S, 010=B, 011=J, 100=U.
- `ALUSrcE` output 1: ALU B operand select. 1 = immediate.
- `ALUControlE` output ALU_W: ALU operation.
- `PCSrcE` output 1: redirect the PC.
- `PCTargetSrcE` output 1: target select. 1 = ALU result (jalr), 0 = PC+imm.
- `ResultSrcEb0` output 1: `ResultSrcE[0]`, used by the hazard unit for load-use detection.
- `RegWriteM`, `MemWriteM` output 1: M-stage control.
- `Funct3M` output 3: load/store width for the memory interface.
- `IllegalM` output 1: an illegal instruction has reached M.
- `RegWriteW` output 1: W-stage register write enable.
- `ResultSrcW` output 2: result select. 00=ALU, 01=memory, 10=PC+4, 11=ImmExt.

## Operation
Decode is combinational on `InstrD`. Any field not listed below is 0.
- lw (0000011): RegWrite, ImmSrc=000, ALUSrc, ResultSrc=01, ALUOp=00.
- sw (0100011): ImmSrc=001, ALUSrc, MemWrite, ALUOp=00.
- R-type (0110011): RegWrite, ALUOp=10.
- I-ALU (0010011): RegWrite, ImmSrc=000, ALUSrc, ALUOp=10.
- branch (1100011): Branch, ImmSrc=010, ALUOp=01.
- jal (1101111): RegWrite, ImmSrc=011, ResultSrc=10, Jump.
- jalr (1100111): RegWrite, ImmSrc=000, ALUSrc, ResultSrc=10, Jump, TargetSrc, ALUOp=00.
- lui (0110111): RegWrite, ImmSrc=100, ResultSrc=11.

Illegal instructions:
- Condition: any other opcode, or a branch with funct3 of 010 or 011.
- All control fields are forced to 0 and `IllegalD`=1. The instruction proceeds as a NOP.

ALUControl encoding:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.

ALU decode:
- ALUOp=00 gives add. ALUOp=01 gives sub.
- ALUOp=10 decodes on funct3:
  - 000: sub if `funct7b5 & op[5]`, else add.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: sra if funct7b5, else srl.
  - 110: or. 111: and.

Pipeline registers:
- D→E register: {RegWrite, ResultSrc, MemWrite, Jump, Branch, TargetSrc, ALUControl, ALUSrc, funct3, Illegal}.
- E→M register: {RegWrite, ResultSrc, MemWrite, funct3, Illegal}.
- M→W register: {RegWrite, ResultSrc}.
- E register update priority: `reset` > `FlushE` (all 0) > `StallE` (hold) > load.
- M register update priority: `reset` > `FlushM` > `StallE` (load bubble, so a held E instruction is not duplicated) > load.
- W register always loads M.

Branch resolution is combinational in E, using `Funct3E`:
- 000 beq: taken if Z.
- 001 bne: taken if !Z.
- 100 blt: taken if N^V.
- 101 bge: taken if !(N^V).
- 110 bltu: taken if !C.
- 111 bgeu: taken if C.

Derived E-stage outputs:
- `PCSrcE = JumpE | (BranchE & taken)`.
- `PCTargetSrcE` = the E-stage TargetSrc bit.
- `PCSrcE` is 0 whenever the E register holds a bubble, including while `StallE` and `FlushE` are both high.

## Timing
- After `reset`, all E/M/W outputs are 0, including `PCSrcE`, `IllegalM` and `ResultSrcW`. `ImmSrcD` follows `InstrD` combinationally.
- Control decoded in cycle n is visible on E outputs in n+1, M outputs in n+2 and W outputs in n+3, absent stalls and flushes.
- With `StallE` held for k cycles:
  - E outputs stay constant.
  - M receives k bubbles.
  - The stalled instruction reaches M one cycle after `StallE` falls.
- `FlushE` and `StallE` asserted together: the flush wins.
- `FlushM` affects only the M register. W receives the bubble on the next edge.
- `reset` asserted mid-stream clears all stages on that edge. Nothing in flight is retained.

## Test plan
- Reset, then check every registered output. Then `add x3,x1,x2` (0x002081B3) → RegWriteE=1, ALUControlE=0000; RegWriteW=1 and ResultSrcW=00 three cycles after decode.
- `sub` (0x402081B3) → ALUControlE=0001. `lw x5,0(x1)` (0x0000A283) → ResultSrcEb0=1, Funct3M=010, ResultSrcW=01.
- `blt x1,x2,8` (0x0020C463) in E:
  - NegE=1, OverflowE=0 → PCSrcE=1.
  - NegE=1, OverflowE=1 → PCSrcE=0.
  - Sweep all six funct3 values against flag combinations.
- `jalr x1,0(x5)` (0x000280E7) → PCSrcE=1, PCTargetSrcE=1, ResultSrcW=10. `lui x5,0x12345` (0x123452B7) → ImmSrcD=100, ResultSrcW=11.
- `lw`, then `StallE` for 2 cycles → E held, M shows 2 bubbles, `lw` reaches M after release. Same run with `FlushE` also high → E cleared, PCSrcE=0.
- Word 0xFFFFFFFF, and a branch with funct3=010 → IllegalM=1 two cycles later, no RegWrite or MemWrite. With `ILLEGAL_EN`=0 → IllegalM stays 0.

Source files
------------

// File: rtl/pipe_controller_v2_if.sv
// Control-unit bus: Decode instruction, E-stage ALU flags and hazard controls
// flow in; per-stage pipeline control flows out.
interface pipe_controller_v2_if #(
  parameter int unsigned ALU_W = 4
);
  logic [31:0]      InstrD;
  logic             ZeroE;
  logic             NegE;
  logic             CarryE;
  logic             OverflowE;
  logic             StallE;
  logic             FlushE;
  logic             FlushM;
  logic [2:0]       ImmSrcD;
  logic             ALUSrcE;
  logic [ALU_W-1:0] ALUControlE;
  logic             PCSrcE;
  logic             PCTargetSrcE;
  logic             ResultSrcEb0;
  logic             RegWriteM;
  logic             MemWriteM;
  logic [2:0]       Funct3M;
  logic             IllegalM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;

  modport master (
    output InstrD, ZeroE, NegE, CarryE, OverflowE, StallE, FlushE, FlushM,
    input  ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, PCTargetSrcE, ResultSrcEb0,
           RegWriteM, MemWriteM, Funct3M, IllegalM, RegWriteW, ResultSrcW
  );

  modport slave (
    input  InstrD, ZeroE, NegE, CarryE, OverflowE, StallE, FlushE, FlushM,
    output ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, PCTargetSrcE, ResultSrcEb0,
           RegWriteM, MemWriteM, Funct3M, IllegalM, RegWriteW, ResultSrcW
  );
endinterface

// File: rtl/pipe_controller_v2.sv
// RV32I five-stage control unit: decodes InstrD, carries control through the
// E/M/W registers, resolves branches in E and flags illegal instructions.
module pipe_controller_v2 #(
  parameter int unsigned ALU_W      = 4,
  parameter bit          ILLEGAL_EN = 1'b1
) (
  input logic                clk,
  input logic                reset,
  pipe_controller_v2_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    AOP_ADD  = 2'b00,
    AOP_SUB  = 2'b01,
    AOP_FUNC = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       target_src;
    alu_ctrl_e  alu_ctrl;
    logic       alu_src;
    logic [2:0] funct3;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] funct3;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  ctrl_e_t    ctrl_d;
  ctrl_e_t    ctrl_e;
  ctrl_m_t    ctrl_m;
  ctrl_w_t    ctrl_w;
  logic [2:0] imm_src_d;
  alu_op_e    alu_op;
  logic       bad_d;
  logic       taken;
  logic [ALU_W-1:0] alu_ctrl_out;
  logic       unused_instr;

  assign opcode       = bus.InstrD[6:0];
  assign funct3       = bus.InstrD[14:12];
  assign funct7b5     = bus.InstrD[30];
  assign unused_instr = ^{bus.InstrD[31], bus.InstrD[29:15], bus.InstrD[11:7]};

  // Main and ALU decode; an illegal word is squashed to an all-zero NOP.
  always_comb begin
    ctrl_d    = '0;
    imm_src_d = 3'b000;
    alu_op    = AOP_ADD;
    bad_d     = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = 2'b01;
      end
      OP_STORE: begin
        imm_src_d        = 3'b001;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        alu_op           = AOP_FUNC;
      end
      OP_IALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_op           = AOP_FUNC;
      end
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          bad_d = 1'b1;
        end else begin
          ctrl_d.branch = 1'b1;
          imm_src_d     = 3'b010;
          alu_op        = AOP_SUB;
        end
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        imm_src_d         = 3'b011;
        ctrl_d.result_src = 2'b10;
        ctrl_d.jump       = 1'b1;
      end
      OP_JALR: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = 2'b10;
        ctrl_d.jump       = 1'b1;
        ctrl_d.target_src = 1'b1;
      end
      OP_LUI: begin
        ctrl_d.reg_write  = 1'b1;
        imm_src_d         = 3'b100;
        ctrl_d.result_src = 2'b11;
      end
      default: bad_d = 1'b1;
    endcase

    ctrl_d.alu_ctrl = ALU_ADD;
    case (alu_op)
      AOP_SUB: ctrl_d.alu_ctrl = ALU_SUB;
      AOP_FUNC: begin
        case (funct3)
          3'b000:  ctrl_d.alu_ctrl = (funct7b5 & opcode[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl_d.alu_ctrl = ALU_SLL;
          3'b010:  ctrl_d.alu_ctrl = ALU_SLT;
          3'b011:  ctrl_d.alu_ctrl = ALU_SLTU;
          3'b100:  ctrl_d.alu_ctrl = ALU_XOR;
          3'b101:  ctrl_d.alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl_d.alu_ctrl = ALU_OR;
          default: ctrl_d.alu_ctrl = ALU_AND;
        endcase
      end
      default: ctrl_d.alu_ctrl = ALU_ADD;
    endcase

    ctrl_d.funct3 = funct3;

    if (bad_d) begin
      ctrl_d    = '0;
      imm_src_d = 3'b000;
    end
  end

  // E register: flush beats stall, stall holds, otherwise load Decode.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ctrl_e <= '0;
    end else if (!bus.StallE) begin
      ctrl_e <= ctrl_d;
    end
  end

  // M register: a stalled E feeds bubbles so the held instruction is not duplicated.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushM || bus.StallE) begin
      ctrl_m <= '0;
    end else begin
      ctrl_m <= '{reg_write:  ctrl_e.reg_write,
                  result_src: ctrl_e.result_src,
                  mem_write:  ctrl_e.mem_write,
                  funct3:     ctrl_e.funct3};
    end
  end

  // W register: always follows M.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_w <= '0;
    end else begin
      ctrl_w <= '{reg_write: ctrl_m.reg_write, result_src: ctrl_m.result_src};
    end
  end

  generate
    if (ILLEGAL_EN) begin : g_illegal
      logic illegal_e;
      logic illegal_m;

      // Illegal flag through E, same update priority as the E register.
      always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
          illegal_e <= 1'b0;
        end else if (!bus.StallE) begin
          illegal_e <= bad_d;
        end
      end

      // Illegal flag through M, same update priority as the M register.
      always_ff @(posedge clk) begin
        if (reset || bus.FlushM || bus.StallE) begin
          illegal_m <= 1'b0;
        end else begin
          illegal_m <= illegal_e;
        end
      end

      assign bus.IllegalM = illegal_m;
    end else begin : g_no_illegal
      assign bus.IllegalM = 1'b0;
    end
  endgenerate

  // Branch condition from E-stage flags; CarryE=1 means no borrow.
  always_comb begin
    taken = 1'b0;
    case (ctrl_e.funct3)
      3'b000:  taken = bus.ZeroE;
      3'b001:  taken = !bus.ZeroE;
      3'b100:  taken = bus.NegE ^ bus.OverflowE;
      3'b101:  taken = !(bus.NegE ^ bus.OverflowE);
      3'b110:  taken = !bus.CarryE;
      3'b111:  taken = bus.CarryE;
      default: taken = 1'b0;
    endcase
  end

  // Zero-extend the 4-bit operation code to the configured ALU width.
  always_comb begin
    alu_ctrl_out      = '0;
    alu_ctrl_out[3:0] = ctrl_e.alu_ctrl;
  end

  assign bus.ImmSrcD      = imm_src_d;
  assign bus.ALUSrcE      = ctrl_e.alu_src;
  assign bus.ALUControlE  = alu_ctrl_out;
  assign bus.PCSrcE       = ctrl_e.jump | (ctrl_e.branch & taken);
  assign bus.PCTargetSrcE = ctrl_e.target_src;
  assign bus.ResultSrcEb0 = ctrl_e.result_src[0];
  assign bus.RegWriteM    = ctrl_m.reg_write;
  assign bus.MemWriteM    = ctrl_m.mem_write;
  assign bus.Funct3M      = ctrl_m.funct3;
  assign bus.RegWriteW    = ctrl_w.reg_write;
  assign bus.ResultSrcW   = ctrl_w.result_src;

endmodule

// File: tb/tb_pipe_controller_v2.sv
// Directed bench for pipe_controller_v2: default instance plus a second
// instance with ALU_W=5 and ILLEGAL_EN=0 sharing the same stimulus.
module tb_pipe_controller_v2;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_JALR  = 32'h000280E7;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_ANDI  = 32'h0010F093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BAD_B = 32'h0020A463;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  pipe_controller_v2_if #(.ALU_W(4)) bus ();
  pipe_controller_v2_if #(.ALU_W(5)) bus2 ();

  assign bus2.InstrD    = bus.InstrD;
  assign bus2.ZeroE     = bus.ZeroE;
  assign bus2.NegE      = bus.NegE;
  assign bus2.CarryE    = bus.CarryE;
  assign bus2.OverflowE = bus.OverflowE;
  assign bus2.StallE    = bus.StallE;
  assign bus2.FlushE    = bus.FlushE;
  assign bus2.FlushM    = bus.FlushM;

  pipe_controller_v2 #(.ALU_W(4), .ILLEGAL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_controller_v2 #(.ALU_W(5), .ILLEGAL_EN(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic br_exp(input logic [2:0] f, input logic [3:0] zncv);
    logic z, n, c, v;
    {z, n, c, v} = zncv;
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n ^ v;
      3'd5:    return !(n ^ v);
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] alu_instr [14];
  logic [3:0]  alu_exp   [14];
  logic [2:0]  br_f      [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;

    alu_instr = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3,
                  32'h0020B1B3, 32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3,
                  32'h0020E1B3, 32'h0020F1B3, 32'hC0008093, 32'h4010D093,
                  32'h0000A283, 32'h00208463};
    alu_exp   = '{4'd0, 4'd1, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd9,
                  4'd3, 4'd2, 4'd0, 4'd9, 4'd0, 4'd1};
    br_f      = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    reset         = 1'b1;
    bus.InstrD    = I_ONES;
    bus.ZeroE     = 1'b0;
    bus.NegE      = 1'b0;
    bus.CarryE    = 1'b0;
    bus.OverflowE = 1'b0;
    bus.StallE    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.FlushM    = 1'b0;

    // Reset state of every registered output.
    tick(); tick(); tick();
    check("rst_alusrc",   bus.ALUSrcE, 0);
    check("rst_aluctl",   bus.ALUControlE, 0);
    check("rst_pcsrc",    bus.PCSrcE, 0);
    check("rst_tgtsrc",   bus.PCTargetSrcE, 0);
    check("rst_rsrc0",    bus.ResultSrcEb0, 0);
    check("rst_regwm",    bus.RegWriteM, 0);
    check("rst_memwm",    bus.MemWriteM, 0);
    check("rst_f3m",      bus.Funct3M, 0);
    check("rst_illm",     bus.IllegalM, 0);
    check("rst_regww",    bus.RegWriteW, 0);
    check("rst_rsrcw",    bus.ResultSrcW, 0);
    reset = 1'b0;

    // Straight-line stream, no stalls.
    bus.InstrD = I_ADD; #1;
    check("imm_add", bus.ImmSrcD, 3'b000);
    tick();
    check("add_aluctl", bus.ALUControlE, 4'd0);
    check("add_alusrc", bus.ALUSrcE, 0);
    bus.InstrD = I_SUB; tick();
    check("sub_aluctl", bus.ALUControlE, 4'd1);
    check("add_regwm",  bus.RegWriteM, 1);
    check("add_f3m",    bus.Funct3M, 0);
    bus.InstrD = I_LW; tick();
    check("lw_rsrc0",   bus.ResultSrcEb0, 1);
    check("lw_alusrc",  bus.ALUSrcE, 1);
    check("add_regww",  bus.RegWriteW, 1);
    check("add_rsrcw",  bus.ResultSrcW, 2'b00);
    bus.InstrD = I_SW; #1;
    check("imm_sw", bus.ImmSrcD, 3'b001);
    tick();
    check("sw_rsrc0",   bus.ResultSrcEb0, 0);
    check("lw_f3m",     bus.Funct3M, 3'b010);
    check("lw_regwm",   bus.RegWriteM, 1);
    bus.InstrD = I_JALR; tick();
    check("jalr_pcsrc", bus.PCSrcE, 1);
    check("jalr_tgt",   bus.PCTargetSrcE, 1);
    check("sw_memwm",   bus.MemWriteM, 1);
    check("sw_regwm",   bus.RegWriteM, 0);
    check("lw_rsrcw",   bus.ResultSrcW, 2'b01);
    bus.InstrD = I_LUI; #1;
    check("imm_lui", bus.ImmSrcD, 3'b100);
    tick();
    check("lui_pcsrc",  bus.PCSrcE, 0);
    check("sw_regww",   bus.RegWriteW, 0);
    bus.InstrD = I_JAL; #1;
    check("imm_jal", bus.ImmSrcD, 3'b011);
    tick();
    check("jal_pcsrc",  bus.PCSrcE, 1);
    check("jal_tgt",    bus.PCTargetSrcE, 0);
    check("jalr_rsrcw", bus.ResultSrcW, 2'b10);
    bus.InstrD = I_ANDI; tick();
    check("andi_aluctl", bus.ALUControlE, 4'd2);
    check("lui_rsrcw",   bus.ResultSrcW, 2'b11);
    check("lui_regww",   bus.RegWriteW, 1);

    // ALU decode table, also checked on the 5-bit ALUControl instance.
    for (int i = 0; i < 14; i++) begin
      bus.InstrD = alu_instr[i];
      tick();
      check($sformatf("aluctl_%0d", i), bus.ALUControlE, alu_exp[i]);
      check($sformatf("aluctl5_%0d", i), bus2.ALUControlE, alu_exp[i]);
    end

    // Branch resolution.
    bus.InstrD = I_BLT; #1;
    check("imm_br", bus.ImmSrcD, 3'b010);
    tick();
    bus.NegE = 1'b1; bus.OverflowE = 1'b0; #1;
    check("blt_n1v0", bus.PCSrcE, 1);
    bus.OverflowE = 1'b1; #1;
    check("blt_n1v1", bus.PCSrcE, 0);
    for (int b = 0; b < 6; b++) begin
      bus.InstrD = I_BEQ | (32'(br_f[b]) << 12);
      tick();
      for (int fl = 0; fl < 16; fl++) begin
        {bus.ZeroE, bus.NegE, bus.CarryE, bus.OverflowE} = 4'(fl);
        #1;
        check($sformatf("br_f%0d_fl%0h", br_f[b], fl), bus.PCSrcE,
              br_exp(br_f[b], 4'(fl)));
      end
    end
    {bus.ZeroE, bus.NegE, bus.CarryE, bus.OverflowE} = 4'b0000;

    // Stall E for two cycles with lw held in E.
    bus.InstrD = I_LW; tick();
    check("stl_lw_e", bus.ResultSrcEb0, 1);
    bus.InstrD = I_ADD; bus.StallE = 1'b1; tick();
    check("stl1_rsrc0", bus.ResultSrcEb0, 1);
    check("stl1_alusrc", bus.ALUSrcE, 1);
    check("stl1_regwm", bus.RegWriteM, 0);
    check("stl1_f3m",   bus.Funct3M, 0);
    tick();
    check("stl2_rsrc0", bus.ResultSrcEb0, 1);
    check("stl2_regwm", bus.RegWriteM, 0);
    bus.StallE = 1'b0; tick();
    check("rel_add_e",  bus.ResultSrcEb0, 0);
    check("rel_lw_regwm", bus.RegWriteM, 1);
    check("rel_lw_f3m", bus.Funct3M, 3'b010);
    tick();
    check("rel_add_f3m", bus.Funct3M, 0);
    check("rel_lw_rsrcw", bus.ResultSrcW, 2'b01);

    // Stall and flush together: the flush wins.
    bus.InstrD = I_JAL; tick();
    check("sf_jal_pcsrc", bus.PCSrcE, 1);
    bus.InstrD = I_LW; bus.StallE = 1'b1; bus.FlushE = 1'b1; tick();
    check("sf_pcsrc",  bus.PCSrcE, 0);
    check("sf_rsrc0",  bus.ResultSrcEb0, 0);
    check("sf_regwm",  bus.RegWriteM, 0);
    bus.StallE = 1'b0; bus.FlushE = 1'b0; tick();
    check("sf_lw_e",   bus.ResultSrcEb0, 1);
    check("sf_bub_m",  bus.RegWriteM, 0);

    // FlushM bubbles only M; W sees it next edge.
    bus.InstrD = I_ADD; tick();
    bus.InstrD = I_SW; bus.FlushM = 1'b1; tick();
    check("fm_regwm",  bus.RegWriteM, 0);
    check("fm_sw_e",   bus.ALUSrcE, 1);
    bus.FlushM = 1'b0; tick();
    check("fm_sw_memwm", bus.MemWriteM, 1);
    check("fm_regww",  bus.RegWriteW, 0);

    // Illegal words.
    bus.InstrD = I_ONES; #1;
    check("ill_imm", bus.ImmSrcD, 3'b000);
    tick();
    check("ill_pcsrc", bus.PCSrcE, 0);
    check("ill_alusrc", bus.ALUSrcE, 0);
    bus.InstrD = I_BAD_B; #1;
    check("badb_imm", bus.ImmSrcD, 3'b000);
    tick();
    check("ill_illm",  bus.IllegalM, 1);
    check("ill_regwm", bus.RegWriteM, 0);
    check("ill_memwm", bus.MemWriteM, 0);
    check("ill_dis",   bus2.IllegalM, 0);
    bus.ZeroE = 1'b1; bus.CarryE = 1'b1; #1;
    check("badb_pcsrc", bus.PCSrcE, 0);
    bus.InstrD = I_ADD; tick();
    check("badb_illm", bus.IllegalM, 1);
    check("badb_dis",  bus2.IllegalM, 0);
    check("ill_regww", bus.RegWriteW, 0);
    tick();
    check("add_illm",  bus.IllegalM, 0);
    bus.ZeroE = 1'b0; bus.CarryE = 1'b0;

    // Mid-stream reset clears everything in flight.
    bus.InstrD = I_JALR; tick();
    bus.InstrD = I_LW; tick();
    bus.InstrD = I_ADD; reset = 1'b1; tick();
    check("mr_pcsrc", bus.PCSrcE, 0);
    check("mr_rsrc0", bus.ResultSrcEb0, 0);
    check("mr_regwm", bus.RegWriteM, 0);
    check("mr_regww", bus.RegWriteW, 0);
    check("mr_rsrcw", bus.ResultSrcW, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
